// File: rtl/guess_game_ctrl.sv
// guess_game_ctrl
//   Game sequencer sitting above a guess FSM. Paces the guess FSM with a
//   speed-dependent step tick and tracks score, lives and speed level.
//   It holds the win/lose result on display for a fixed time, then re-arms
//   the next round, or stops in a game-over state when lives run out.
//
// State table
//   state   | meaning
//   IDLE    | waiting for start after reset; guess FSM held in its start state
//   ARM     | one-cycle round setup; guess FSM held, step divider cleared
//   PLAY    | round in progress; step ticks issued, win/lose accepted
//   RESULT  | win/lose lamps shown for HOLD cycles, then back to ARM
//   OVER    | no lives left; results frozen until start
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   new-game pulse, honoured in IDLE and OVER only
//   win        in   win flag from the guess FSM
//   lose       in   lose flag from the guess FSM
//   en         out  one-cycle step tick to the guess FSM
//   fsm_rst    out  holds the guess FSM in its start state
//   score      out  wins this game, saturating at 15
//   lives      out  lives remaining
//   level      out  speed level 0..3; tick period is BASE_DIV >> level
//   game_over  out  high in OVER
//   busy       out  high in ARM, PLAY and RESULT

module guess_game_ctrl #(
    parameter int BASE_DIV       = 2000000,
    parameter int HOLD           = 50000000,
    parameter int LIVES          = 3,
    parameter int WINS_PER_LEVEL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       win,
    input  logic       lose,
    output logic       en,
    output logic       fsm_rst,
    output logic [3:0] score,
    output logic [1:0] lives,
    output logic [1:0] level,
    output logic       game_over,
    output logic       busy
);

    localparam int DIV_W  = $clog2(BASE_DIV);
    localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;

    localparam logic [1:0]        LIVES_INIT = 2'(LIVES);
    localparam logic [3:0]        WPL        = 4'(WINS_PER_LEVEL);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_PLAY,
        S_RESULT,
        S_OVER
    } state_t;

    state_t            state;
    logic [DIV_W-1:0]  div_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [3:0]        win_cnt;
    logic [DIV_W-1:0]  div_last;

    // Terminal count of the step divider for the current level. The level
    // only changes when leaving PLAY, so a new speed applies from the next
    // PLAY entry onwards.
    assign div_last = DIV_W'((BASE_DIV >> level) - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            en        <= 1'b0;
            fsm_rst   <= 1'b1;
            score     <= 4'd0;
            lives     <= LIVES_INIT;
            level     <= 2'd0;
            game_over <= 1'b0;
            busy      <= 1'b0;
            div_cnt   <= '0;
            hold_cnt  <= '0;
            win_cnt   <= 4'd0;
        end else begin
            en <= 1'b0;
            case (state)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        state     <= S_ARM;
                        fsm_rst   <= 1'b1;
                        busy      <= 1'b1;
                        game_over <= 1'b0;
                        score     <= 4'd0;
                        lives     <= LIVES_INIT;
                        level     <= 2'd0;
                        win_cnt   <= 4'd0;
                        div_cnt   <= '0;
                        hold_cnt  <= '0;
                    end
                end

                S_ARM: begin
                    state   <= S_PLAY;
                    fsm_rst <= 1'b0;
                    div_cnt <= '0;
                end

                S_PLAY: begin
                    // A loss wins over a simultaneous win; no tick is issued
                    // in the cycle a result is accepted.
                    if (lose) begin
                        lives    <= lives - 2'd1;
                        div_cnt  <= '0;
                        hold_cnt <= '0;
                        if (lives == 2'd1) begin
                            state     <= S_OVER;
                            busy      <= 1'b0;
                            game_over <= 1'b1;
                        end else begin
                            state <= S_RESULT;
                        end
                    end else if (win) begin
                        state    <= S_RESULT;
                        div_cnt  <= '0;
                        hold_cnt <= '0;
                        if (score != 4'd15) begin
                            score <= score + 4'd1;
                        end
                        if (win_cnt + 4'd1 == WPL) begin
                            win_cnt <= 4'd0;
                            if (level != 2'd3) begin
                                level <= level + 2'd1;
                            end
                        end else begin
                            win_cnt <= win_cnt + 4'd1;
                        end
                    end else if (div_cnt == div_last) begin
                        en      <= 1'b1;
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                S_RESULT: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state    <= S_ARM;
                        fsm_rst  <= 1'b1;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    fsm_rst <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/guess_game_ctrl.md
GUESS_GAME_CTRL -- requirements
Module: guess_game_ctrl

Interface
REQ-001 Parameter BASE_DIV, default 2000000; clock cycles between en ticks at level 0; must be at least 16.
REQ-002 Parameter HOLD, default 50000000; clock cycles the result is displayed after a win or loss.
REQ-003 Parameter LIVES, default 3, range 1..3; lives at game start.
REQ-004 Parameter WINS_PER_LEVEL, default 4, range 1..15; wins needed per level-up.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-006 clk  in  1  system clock; all state changes on the rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 start  in  1  single-cycle pulse that begins a new game; honoured only in IDLE or OVER.
REQ-009 win  in  1  win flag from the guess FSM.
REQ-010 lose  in  1  lose flag from the guess FSM.
REQ-011 en  out  1  single-cycle step tick to the guess FSM.
REQ-012 fsm_rst  out  1  holds the guess FSM in its start state.
REQ-013 score  out  4  wins this game, saturating.
REQ-014 lives  out  2  lives remaining.
REQ-015 level  out  2  speed level, 0..3.
REQ-016 game_over  out  1  high while in OVER.
REQ-017 busy  out  1  high in ARM, PLAY and RESULT.

Function
REQ-018 The FSM SHALL have states IDLE, ARM, PLAY, RESULT and OVER; all outputs are registered.
REQ-019 IDLE: fsm_rst=1, en=0; start -> ARM, with score=0, lives=LIVES, level=0 and the win counter set to 0.
REQ-020 ARM: lasts exactly 1 cycle; fsm_rst=1, divider cleared; -> PLAY.
REQ-021 PLAY: fsm_rst=0; the divider counts cycles; en=1 for one cycle when the count reaches (BASE_DIV>>level)-1, then the count wraps to 0.
REQ-022 In PLAY, the first en SHALL occur (BASE_DIV>>level) cycles after PLAY entry.
REQ-023 PLAY with lose=1 (regardless of win): lives decrements; if the new lives value is 0 -> OVER, otherwise -> RESULT.
REQ-024 PLAY with win=1 and lose=0: score+1 (saturates at 15); win counter+1; when the win counter reaches WINS_PER_LEVEL it resets to 0 and level+1 (saturates at 3); -> RESULT.
REQ-025 A level change SHALL take effect on the next PLAY entry.
REQ-026 No en pulse SHALL be issued in the cycle a win or lose is accepted, nor outside PLAY.
REQ-027 RESULT: en=0, fsm_rst=0 so the win/lose lamps stay visible; after HOLD cycles -> ARM.
REQ-028 OVER: game_over=1, en=0, fsm_rst=0; score, level and lives are frozen; start -> ARM with the new-game initialisation of REQ-019.
REQ-029 start SHALL be ignored in ARM, PLAY and RESULT.
REQ-030 win and lose SHALL be ignored outside PLAY.
REQ-031 The divider and hold counter SHALL be sized by $clog2 of their parameters, and neither counter overflows.

Reset
REQ-032 rst=1 at a clock edge: state=IDLE, en=0, fsm_rst=1, score=0, lives=LIVES, level=0, game_over=0, busy=0, all counters 0.
REQ-033 rst SHALL take priority over every input and abort any state, including mid-PLAY and mid-RESULT.

Verification
Bench parameters: BASE_DIV=16, HOLD=4, LIVES=2, WINS_PER_LEVEL=2.
REQ-034 Start tick spacing: rst, then start -> ARM for 1 cycle, then en pulses every 16 cycles with the first 16 cycles after PLAY entry; busy=1 and fsm_rst=0 in PLAY.
REQ-035 Level-up: two accepted wins -> score=2, level=1; next PLAY has en spacing of 8 cycles; RESULT lasts 4 cycles with en=0.
REQ-036 Game over: two losses -> lives 2->1->0; second loss goes directly to OVER, game_over=1, en=0; start -> lives=2, score=0, level=0.
REQ-037 Simultaneous flags: win=1 and lose=1 in PLAY -> treated as a loss; score unchanged; lives-1.
REQ-038 Saturation: 16+ wins with lives retained -> score holds at 15, level holds at 3, en spacing 2 cycles.
REQ-039 Reset mid-RESULT: rst asserted -> next cycle IDLE with all REQ-032 values; a start pulsed in PLAY is ignored.
